hs_dcr_if_mp: RTL and testbench
===============================

Name: hs_dcr_if_mp

Overview:
- Multi-port successor to the single-port SATA host DCR register interface.
- One shared DCR slave serves C_NUM_PORTS identical per-port register banks, each with:
  - linkup/plllock change detection and a DMA request/ack handshake;
  - a W1C sticky interrupt status with a per-source enable mask;
  - a counted StartComm pulse.
- Sits between the DCR/bus bridge and the per-port link/DMA engines. Produces a per-port irq and a global irq.

Parameters:
- C_NUM_PORTS, 4, number of port banks (1..8).
- C_AW, 8, word-address width of the address port.
- C_LEN_W, 16, DMA length field width (≤ 24).
- C_COM_PULSE, 4, StartComm pulse length in cycles (1..15).
- C_SYNC_STAGES, 2, synchroniser depth for linkup/plllock (≥ 2).

Ports:
- sys_clk  in  1  the single clock.
- sys_rst_n  in  1  reset. Synchronous, active-low.
- address  in  C_AW  word address.
- write  in  1  one-cycle write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- irq  out  1  OR of port_irq.
- port_irq  out  N  per-port masked interrupt.
- linkup, plllock  in  N  asynchronous per-port status.
- rxfifo_irq, cxfifo_irq  in  N  per-port level interrupts (sys_clk domain).
- dma_ack  in  N  one-cycle completion per port.
- dma_req  out  N  per-port request, held until ack.
- dma_address  out  32N  per-port DMA address.
- dma_length  out  C_LEN_W*N  per-port DMA length.
- dma_ctl  out  8N  per-port {ok,data,wrt,sync,flush,eof,sof,rsvd}.
- cxfifo_ack  out  N  one-cycle pulse.
- StartComm  out  N  C_COM_PULSE-cycle pulse.
- phyreset  out  N  level.

Behaviour:
- Address decode:
  - port = address[C_AW-1:2], reg = address[1:0].
  - port ≥ C_NUM_PORTS: reads return 0, writes are ignored.
  - Registers: 0 STAT/CTRL, 1 DMA_CTRL, 2 DMA_ADDR, 3 IRQ_EN.
- Read path:
  - readdata is registered; valid 1 cycle after address is presented.
  - Reads have no side effects.
  - Reset value is 0.
- STAT read layout:
  - [0] linkup_s, [1] plllock_s.
  - [8:4] masked-before-enable status {cxfifo, rxfifo, dma_done, plllock_cg, linkup_cg}.
  - [9] dma_err, [31] phyreset.
- STAT write:
  - [4]/[5]/[6]/[9] = 1 clears the matching sticky bit (W1C).
  - [28] = 1 starts a StartComm pulse.
  - [30] = 1 sets phyreset; [29] = 1 clears phyreset (set wins if both are 1).
  - [31] = 1 emits a cxfifo_ack pulse the next cycle.
- Synchroniser: linkup/plllock each pass through a C_SYNC_STAGES-flop chain. A change between the last two flops sets the sticky bit.
- Sticky set/clear: a set and a W1C clear in the same cycle leaves the bit SET. Bits [8:7] are live levels, not sticky; writes to them are ignored.
- DMA_CTRL layout: [C_LEN_W-1:0] length, [31:24] ctl byte, [30] req.
  - A write with [30] = 1 is accepted if dma_req = 0, or if dma_ack for that port is high in the same cycle. Accepting latches length and ctl and sets dma_req.
  - A write while dma_req = 1 and no ack: fields and req are unchanged, dma_err is set.
  - A write with [30] = 0 updates length and ctl only when dma_req = 0.
  - dma_ack: dma_req clears the next cycle and dma_done is set.
  - An ack arriving while dma_req = 0 is ignored; dma_done is not set.
  - Reading DMA_CTRL returns {ctl with [30] = dma_req, length}.
- DMA_ADDR: written any time; dma_address updates the next cycle. Software must not change it while req = 1 (the block does not check).
- IRQ_EN: bits [4:0] mask status [8:4]. Reset value is 0.
- port_irq[p] = |(status & en), registered (1 cycle). irq = |port_irq, combinational from the registers.
- StartComm FSM per port:
  - States: IDLE → PULSE (counter loads C_COM_PULSE-1) → IDLE when the counter reaches 0.
  - A start request during PULSE reloads the counter, extending the pulse.
- Reset (sys_rst_n = 0 at a clock edge): all outputs, status, enables, counters and sync flops are 0. phyreset is 0. An in-flight DMA request is dropped.

Decomposition:
- Shared package hs_dcr_pkg holds:
  - register offsets REG_STAT/REG_DMA_CTRL/REG_DMA_ADDR/REG_IRQ_EN;
  - status bit indices;
  - the dma_ctl bit positions.
- One natural sub-module: hs_dcr_port_bank, one per port in a generate loop, containing the sync, sticky status, DMA handshake and StartComm FSM.
- The top level holds only decode, the read mux and the irq OR.

Test Plan:
- Reset with all inputs 0 → readdata = 0, dma_req = 0, StartComm = 0, irq = 0. Read port 2 STAT → 0x0.
- Toggle linkup[1] 0→1 with IRQ_EN[1] = 0x1 → STAT[4] = 1 within C_SYNC_STAGES+1 cycles, port_irq[1] = 1, irq = 1. Write STAT 0x10 → bit clears, irq = 0.
- Write port0 DMA_CTRL 0x4000_0200:
  - dma_req[0] = 1 and dma_length = 0x200;
  - a second write 0x4000_0100 → length stays 0x200, STAT[9] = 1;
  - dma_ack → req = 0, STAT[6] = 1.
- dma_ack[3] and a DMA_CTRL write with req in the same cycle → new request accepted, dma_req[3] stays 1, dma_done set.
- Write STAT 0x1000_0000 to port 1, repeated 2 cycles later (C_COM_PULSE = 4) → StartComm[1] high for 6 consecutive cycles; other ports stay 0.
- Address with port index 5 (N = 4): write → no state change; read → 0. Assert sys_rst_n = 0 mid-DMA → dma_req clears the next edge.

Source files
------------

// File: rtl/hs_dcr_pkg.sv
// Shared definitions for the multi-port SATA host DCR register interface:
// register map, STAT bit positions and the DMA control byte layout.
package hs_dcr_pkg;

  typedef enum logic [1:0] {
    REG_STAT     = 2'd0,
    REG_DMA_CTRL = 2'd1,
    REG_DMA_ADDR = 2'd2,
    REG_IRQ_EN   = 2'd3
  } reg_e;

  // STAT read positions
  localparam int ST_LINKUP_S   = 0;
  localparam int ST_PLLLOCK_S  = 1;
  localparam int ST_LINKUP_CG  = 4;
  localparam int ST_PLLLOCK_CG = 5;
  localparam int ST_DMA_DONE   = 6;
  localparam int ST_DMA_ERR    = 9;
  localparam int ST_PHYRESET   = 31;

  // STAT write command bits
  localparam int WR_STARTCOMM  = 28;
  localparam int WR_PHY_CLR    = 29;
  localparam int WR_PHY_SET    = 30;
  localparam int WR_CXFIFO_ACK = 31;

  localparam int DMA_CTL_LO  = 24;
  localparam int DMA_REQ_BIT = 30;

  typedef struct packed {
    logic ok;
    logic data;
    logic wrt;
    logic sync;
    logic flush;
    logic eof;
    logic sof;
    logic rsvd;
  } dma_ctl_t;

  // Interrupt sources in STAT[8:4] order, matched bit-for-bit by IRQ_EN[4:0]
  typedef struct packed {
    logic cxfifo;
    logic rxfifo;
    logic dma_done;
    logic plllock_cg;
    logic linkup_cg;
  } irq_stat_t;

  typedef enum logic {
    SC_IDLE  = 1'b0,
    SC_PULSE = 1'b1
  } sc_state_e;

endpackage

// File: rtl/hs_dcr_port_bank.sv
// One port's register bank: status synchronisers, sticky interrupt status,
// DMA request/ack handshake and the StartComm pulse generator.
module hs_dcr_port_bank
  import hs_dcr_pkg::*;
#(
  parameter int C_LEN_W       = 16,
  parameter int C_COM_PULSE   = 4,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [1:0]         i_reg,
  input  logic [31:0]        i_wdata,
  input  logic               i_linkup,
  input  logic               i_plllock,
  input  logic               i_rxfifo_irq,
  input  logic               i_cxfifo_irq,
  input  logic               i_dma_ack,
  output logic [31:0]        o_rdata,
  output logic               o_irq,
  output logic               o_dma_req,
  output logic [31:0]        o_dma_address,
  output logic [C_LEN_W-1:0] o_dma_length,
  output logic [7:0]         o_dma_ctl,
  output logic               o_cxfifo_ack,
  output logic               o_startcomm,
  output logic               o_phyreset
);

  localparam int         S           = C_SYNC_STAGES;
  localparam logic [3:0] LP_CNT_LOAD = 4'(C_COM_PULSE - 1);

  reg_e               w_reg;
  logic               w_wr_stat, w_wr_dma, w_wr_addr, w_wr_en;
  logic               w_lk_cg, w_pl_cg, w_sc_start;
  logic               w_req_wr, w_accept, w_busy_err, w_done;
  irq_stat_t          w_status;
  logic [S-1:0]       r_lk_sync, r_pl_sync;
  logic               r_lk_cg, r_pl_cg, r_done, r_err;
  logic               r_phy, r_cx_ack, r_irq, r_req, r_sc;
  logic [4:0]         r_en;
  logic [C_LEN_W-1:0] r_len;
  dma_ctl_t           r_ctl;
  logic [31:0]        r_addr;
  sc_state_e          r_sc_state;
  logic [3:0]         r_sc_cnt;

  assign w_reg      = reg_e'(i_reg);
  assign w_wr_stat  = i_wr && (w_reg == REG_STAT);
  assign w_wr_dma   = i_wr && (w_reg == REG_DMA_CTRL);
  assign w_wr_addr  = i_wr && (w_reg == REG_DMA_ADDR);
  assign w_wr_en    = i_wr && (w_reg == REG_IRQ_EN);
  assign w_sc_start = w_wr_stat && i_wdata[WR_STARTCOMM];

  assign w_lk_cg = r_lk_sync[S-1] ^ r_lk_sync[S-2];
  assign w_pl_cg = r_pl_sync[S-1] ^ r_pl_sync[S-2];

  // A same-cycle ack frees the channel, so a back-to-back request is accepted
  assign w_req_wr   = w_wr_dma && i_wdata[DMA_REQ_BIT];
  assign w_accept   = w_req_wr && (!r_req || i_dma_ack);
  assign w_busy_err = w_req_wr && r_req && !i_dma_ack;
  assign w_done     = r_req && i_dma_ack;

  assign w_status = '{cxfifo: i_cxfifo_irq, rxfifo: i_rxfifo_irq, dma_done: r_done,
                      plllock_cg: r_pl_cg, linkup_cg: r_lk_cg};

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lk_sync <= '0;
      r_pl_sync <= '0;
      r_lk_cg   <= 1'b0;
      r_pl_cg   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_en      <= '0;
      r_phy     <= 1'b0;
      r_cx_ack  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_lk_sync <= {r_lk_sync[S-2:0], i_linkup};
      r_pl_sync <= {r_pl_sync[S-2:0], i_plllock};
      // set term is OR-ed last so it wins over a same-cycle W1C
      r_lk_cg   <= w_lk_cg    | (r_lk_cg & !(w_wr_stat && i_wdata[ST_LINKUP_CG]));
      r_pl_cg   <= w_pl_cg    | (r_pl_cg & !(w_wr_stat && i_wdata[ST_PLLLOCK_CG]));
      r_done    <= w_done     | (r_done  & !(w_wr_stat && i_wdata[ST_DMA_DONE]));
      r_err     <= w_busy_err | (r_err   & !(w_wr_stat && i_wdata[ST_DMA_ERR]));
      if (w_wr_en) r_en <= i_wdata[4:0];
      if (w_wr_stat && i_wdata[WR_PHY_SET])      r_phy <= 1'b1;
      else if (w_wr_stat && i_wdata[WR_PHY_CLR]) r_phy <= 1'b0;
      r_cx_ack  <= w_wr_stat && i_wdata[WR_CXFIFO_ACK];
      r_irq     <= |(w_status & r_en);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req  <= 1'b0;
      r_len  <= '0;
      r_ctl  <= '0;
      r_addr <= '0;
    end else begin
      if (w_accept) begin
        r_req <= 1'b1;
        r_len <= i_wdata[C_LEN_W-1:0];
        r_ctl <= dma_ctl_t'(i_wdata[DMA_CTL_LO +: 8]);
      end else begin
        if (w_done) r_req <= 1'b0;
        if (w_wr_dma && !i_wdata[DMA_REQ_BIT] && !r_req) begin
          r_len <= i_wdata[C_LEN_W-1:0];
          r_ctl <= dma_ctl_t'(i_wdata[DMA_CTL_LO +: 8]);
        end
      end
      if (w_wr_addr) r_addr <= i_wdata;
    end
  end

  // A start during PULSE reloads the counter, stretching the pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sc_state <= SC_IDLE;
      r_sc_cnt   <= '0;
      r_sc       <= 1'b0;
    end else begin
      case (r_sc_state)
        SC_IDLE: if (w_sc_start) begin
          r_sc_state <= SC_PULSE;
          r_sc_cnt   <= LP_CNT_LOAD;
          r_sc       <= 1'b1;
        end
        SC_PULSE: begin
          if (w_sc_start) begin
            r_sc_cnt <= LP_CNT_LOAD;
          end else if (r_sc_cnt == 4'd0) begin
            r_sc_state <= SC_IDLE;
            r_sc       <= 1'b0;
          end else begin
            r_sc_cnt <= r_sc_cnt - 4'd1;
          end
        end
        default: begin
          r_sc_state <= SC_IDLE;
          r_sc       <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    o_rdata = '0;
    case (w_reg)
      REG_STAT: begin
        o_rdata[ST_LINKUP_S]           = r_lk_sync[S-1];
        o_rdata[ST_PLLLOCK_S]          = r_pl_sync[S-1];
        o_rdata[ST_LINKUP_CG +: 5]     = w_status;
        o_rdata[ST_DMA_ERR]            = r_err;
        o_rdata[ST_PHYRESET]           = r_phy;
      end
      REG_DMA_CTRL: begin
        o_rdata[C_LEN_W-1:0]           = r_len;
        o_rdata[DMA_CTL_LO +: 8]       = r_ctl;
        o_rdata[DMA_REQ_BIT]           = r_req;
      end
      REG_DMA_ADDR: o_rdata            = r_addr;
      REG_IRQ_EN:   o_rdata[4:0]       = r_en;
      default:      o_rdata            = '0;
    endcase
  end

  assign o_irq         = r_irq;
  assign o_dma_req     = r_req;
  assign o_dma_address = r_addr;
  assign o_dma_length  = r_len;
  assign o_dma_ctl     = r_ctl;
  assign o_cxfifo_ack  = r_cx_ack;
  assign o_startcomm   = r_sc;
  assign o_phyreset    = r_phy;

endmodule

// File: rtl/hs_dcr_if_mp.sv
// Multi-port SATA host DCR slave: address decode into per-port banks,
// registered read mux and the global interrupt OR.
module hs_dcr_if_mp
  import hs_dcr_pkg::*;
#(
  parameter int C_NUM_PORTS   = 4,
  parameter int C_AW          = 8,
  parameter int C_LEN_W       = 16,
  parameter int C_COM_PULSE   = 4,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [C_AW-1:0]              address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         irq,
  output logic [C_NUM_PORTS-1:0]       port_irq,
  input  logic [C_NUM_PORTS-1:0]       linkup,
  input  logic [C_NUM_PORTS-1:0]       plllock,
  input  logic [C_NUM_PORTS-1:0]       rxfifo_irq,
  input  logic [C_NUM_PORTS-1:0]       cxfifo_irq,
  input  logic [C_NUM_PORTS-1:0]       dma_ack,
  output logic [C_NUM_PORTS-1:0]       dma_req,
  output logic [32*C_NUM_PORTS-1:0]    dma_address,
  output logic [C_LEN_W*C_NUM_PORTS-1:0] dma_length,
  output logic [8*C_NUM_PORTS-1:0]     dma_ctl,
  output logic [C_NUM_PORTS-1:0]       cxfifo_ack,
  output logic [C_NUM_PORTS-1:0]       StartComm,
  output logic [C_NUM_PORTS-1:0]       phyreset
);

  localparam int PW = C_AW - 2;

  logic [PW-1:0] w_port;
  logic [1:0]    w_reg;
  logic [31:0]   w_rd [C_NUM_PORTS];
  logic [31:0]   w_rd_mux;

  assign w_port = address[C_AW-1:2];
  assign w_reg  = address[1:0];

  // Port indices with no bank match no write enable and read back as zero
  for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
    hs_dcr_port_bank #(
      .C_LEN_W      (C_LEN_W),
      .C_COM_PULSE  (C_COM_PULSE),
      .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_bank (
      .i_clk        (sys_clk),
      .i_rst_n      (sys_rst_n),
      .i_wr         (write && (w_port == PW'(p))),
      .i_reg        (w_reg),
      .i_wdata      (writedata),
      .i_linkup     (linkup[p]),
      .i_plllock    (plllock[p]),
      .i_rxfifo_irq (rxfifo_irq[p]),
      .i_cxfifo_irq (cxfifo_irq[p]),
      .i_dma_ack    (dma_ack[p]),
      .o_rdata      (w_rd[p]),
      .o_irq        (port_irq[p]),
      .o_dma_req    (dma_req[p]),
      .o_dma_address(dma_address[32*p +: 32]),
      .o_dma_length (dma_length[C_LEN_W*p +: C_LEN_W]),
      .o_dma_ctl    (dma_ctl[8*p +: 8]),
      .o_cxfifo_ack (cxfifo_ack[p]),
      .o_startcomm  (StartComm[p]),
      .o_phyreset   (phyreset[p])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      if (w_port == PW'(p)) w_rd_mux = w_rd[p];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) readdata <= '0;
    else            readdata <= w_rd_mux;
  end

  assign irq = |port_irq;

endmodule

// File: tb/tb_hs_dcr_if_mp.sv
// Directed bench for hs_dcr_if_mp: every expectation is compared immediately
// by check() after the stimulus edge it depends on.
module tb_hs_dcr_if_mp;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int LW = 16;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [AW-1:0]   address;
  logic            write;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic            irq;
  logic [N-1:0]    port_irq;
  logic [N-1:0]    linkup, plllock, rxfifo_irq, cxfifo_irq, dma_ack;
  logic [N-1:0]    dma_req, cxfifo_ack, StartComm, phyreset;
  logic [32*N-1:0] dma_address;
  logic [LW*N-1:0] dma_length;
  logic [8*N-1:0]  dma_ctl;

  hs_dcr_if_mp #(
    .C_NUM_PORTS(N), .C_AW(AW), .C_LEN_W(LW), .C_COM_PULSE(4), .C_SYNC_STAGES(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .port_irq(port_irq),
    .linkup(linkup), .plllock(plllock), .rxfifo_irq(rxfifo_irq), .cxfifo_irq(cxfifo_irq),
    .dma_ack(dma_ack), .dma_req(dma_req), .dma_address(dma_address),
    .dma_length(dma_length), .dma_ctl(dma_ctl), .cxfifo_ack(cxfifo_ack),
    .StartComm(StartComm), .phyreset(phyreset)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {S_RD, S_REQ, S_IRQ, S_PIRQ, S_SC, S_LEN, S_CTL, S_ADDR, S_CXACK, S_PHY} sig_e;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] sample(sig_e sel, int port);
    case (sel)
      S_RD:    return readdata;
      S_REQ:   return 32'(dma_req);
      S_IRQ:   return 32'(irq);
      S_PIRQ:  return 32'(port_irq);
      S_SC:    return 32'(StartComm);
      S_LEN:   return 32'(dma_length[port*LW +: LW]);
      S_CTL:   return 32'(dma_ctl[port*8 +: 8]);
      S_ADDR:  return dma_address[port*32 +: 32];
      S_CXACK: return 32'(cxfifo_ack);
      S_PHY:   return 32'(phyreset);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input sig_e sel, input int port, input logic [31:0] exp);
    check(name, sample(sel, port), exp);
  endtask

  task automatic rd(input string name, input int port, input int rg, input logic [31:0] exp);
    address = AW'(port * 4 + rg);
    write   = 1'b0;
    tick();
    check(name, readdata, exp);
  endtask

  task automatic wr(input int port, input int rg, input logic [31:0] d);
    address   = AW'(port * 4 + rg);
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
    linkup = '0; plllock = '0; rxfifo_irq = '0; cxfifo_irq = '0; dma_ack = '0;
    repeat (3) tick();
    chk("rst_readdata", S_RD, 0, 32'h0);
    chk("rst_dma_req", S_REQ, 0, 32'h0);
    chk("rst_startcomm", S_SC, 0, 32'h0);
    chk("rst_irq", S_IRQ, 0, 32'h0);
    sys_rst_n = 1'b1;
    tick();
    rd("p2_stat_after_reset", 2, 0, 32'h0);

    // linkup change on port 1 with its enable set
    wr(1, 3, 32'h1);
    rd("p1_irq_en", 1, 3, 32'h1);
    linkup[1] = 1'b1;
    repeat (3) tick();
    chk("p1_port_irq_set", S_PIRQ, 0, 32'h2);
    chk("irq_set", S_IRQ, 0, 32'h1);
    rd("p1_stat_linkup_cg", 1, 0, 32'h11);
    wr(1, 0, 32'h10);
    tick();
    chk("p1_port_irq_clr", S_PIRQ, 0, 32'h0);
    chk("irq_clr", S_IRQ, 0, 32'h0);
    rd("p1_stat_after_w1c", 1, 0, 32'h01);

    // plllock change on port 2 (masked), then live rxfifo level
    plllock[2] = 1'b1;
    repeat (3) tick();
    chk("p2_masked_no_irq", S_PIRQ, 0, 32'h0);
    rd("p2_stat_pll_cg", 2, 0, 32'h22);
    wr(2, 0, 32'h20);
    rd("p2_stat_pll_w1c", 2, 0, 32'h02);
    rxfifo_irq[2] = 1'b1;
    rd("p2_stat_rxfifo_live", 2, 0, 32'h82);
    wr(2, 0, 32'h180);
    rd("p2_stat_live_not_w1c", 2, 0, 32'h82);
    rxfifo_irq[2] = 1'b0;

    // port 0 DMA handshake
    wr(0, 1, 32'h4000_0200);
    chk("p0_dma_req_set", S_REQ, 0, 32'h1);
    chk("p0_dma_len", S_LEN, 0, 32'h200);
    chk("p0_dma_ctl", S_CTL, 0, 32'h40);
    wr(0, 1, 32'h4000_0100);
    chk("p0_len_held_busy", S_LEN, 0, 32'h200);
    chk("p0_req_held_busy", S_REQ, 0, 32'h1);
    rd("p0_dmactrl_busy", 0, 1, 32'h4000_0200);
    rd("p0_stat_err", 0, 0, 32'h200);
    dma_ack[0] = 1'b1;
    tick();
    dma_ack[0] = 1'b0;
    chk("p0_req_cleared", S_REQ, 0, 32'h0);
    rd("p0_stat_done_err", 0, 0, 32'h240);
    rd("p0_dmactrl_idle", 0, 1, 32'h0000_0200);
    wr(0, 0, 32'h240);
    dma_ack[0] = 1'b1;
    tick();
    dma_ack[0] = 1'b0;
    rd("p0_stray_ack_ignored", 0, 0, 32'h0);
    wr(0, 1, 32'h8100_0033);
    chk("p0_idle_len_update", S_LEN, 0, 32'h33);
    chk("p0_idle_ctl_update", S_CTL, 0, 32'h81);
    chk("p0_idle_no_req", S_REQ, 0, 32'h0);
    rd("p0_dmactrl_update", 0, 1, 32'h8100_0033);

    // cxfifo_ack pulse and phyreset set/clear
    wr(0, 0, 32'h8000_0000);
    chk("p0_cxack_pulse", S_CXACK, 0, 32'h1);
    tick();
    chk("p0_cxack_end", S_CXACK, 0, 32'h0);
    wr(0, 0, 32'h6000_0000);
    chk("p0_phy_set_wins", S_PHY, 0, 32'h1);
    rd("p0_stat_phy", 0, 0, 32'h8000_0000);
    wr(0, 0, 32'h2000_0000);
    chk("p0_phy_clr", S_PHY, 0, 32'h0);

    // port 3: ack and new request in the same cycle
    wr(3, 1, 32'h4000_0055);
    chk("p3_req_set", S_REQ, 0, 32'h8);
    dma_ack[3] = 1'b1;
    wr(3, 1, 32'h4000_0077);
    dma_ack[3] = 1'b0;
    chk("p3_req_kept", S_REQ, 0, 32'h8);
    chk("p3_len_new", S_LEN, 3, 32'h77);
    rd("p3_stat_done_no_err", 3, 0, 32'h40);
    dma_ack[3] = 1'b1;
    tick();
    dma_ack[3] = 1'b0;
    chk("p3_req_done", S_REQ, 0, 32'h0);

    // StartComm on port 1, restarted two cycles later
    chk("sc_idle", S_SC, 0, 32'h0);
    wr(1, 0, 32'h1000_0000);
    chk("sc_c1", S_SC, 0, 32'h2);
    tick();
    chk("sc_c2", S_SC, 0, 32'h2);
    wr(1, 0, 32'h1000_0000);
    chk("sc_c3", S_SC, 0, 32'h2);
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk($sformatf("sc_c%0d", i), S_SC, 0, 32'h2);
    end
    tick();
    chk("sc_end", S_SC, 0, 32'h0);

    // out-of-range port index 5
    wr(5, 3, 32'h1F);
    wr(5, 1, 32'h4000_0123);
    wr(5, 0, 32'h5000_0000);
    chk("oor_no_req", S_REQ, 0, 32'h0);
    chk("oor_no_phy", S_PHY, 0, 32'h0);
    chk("oor_no_sc", S_SC, 0, 32'h0);
    rd("oor_read_en", 5, 3, 32'h0);
    rd("p1_en_untouched", 1, 3, 32'h1);
    rd("oor_read_stat", 5, 0, 32'h0);

    // reset in the middle of a DMA request
    wr(2, 2, 32'hDEAD_BEEF);
    chk("p2_dma_addr", S_ADDR, 2, 32'hDEAD_BEEF);
    wr(2, 1, 32'h4000_0010);
    chk("p2_req_set", S_REQ, 0, 32'h4);
    sys_rst_n = 1'b0;
    tick();
    chk("rst_mid_dma_req", S_REQ, 0, 32'h0);
    chk("rst_mid_dma_addr", S_ADDR, 2, 32'h0);
    chk("rst_mid_readdata", S_RD, 0, 32'h0);
    sys_rst_n = 1'b1;
    tick();
    rd("p2_dmactrl_after_reset", 2, 1, 32'h0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
